// File: rtl/sram_share_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store,
// with data priority, a fetch anti-starvation limit and per-requester response routing.
module sram_share_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_rvalid_o,
    output logic [31:0]       inst_rdata_o,
    input  logic              data_req_i,
    input  logic [3:0]        data_wen_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              sram_en_o,
    output logic [3:0]        sram_wen_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    localparam int               SW         = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    logic [SW-1:0] streak_q, streak_d;
    logic          owner_valid_q, owner_valid_d;
    owner_e        owner_q, owner_d;
    logic [31:0]   inst_rdata_q, inst_rdata_d;
    logic [31:0]   data_rdata_q, data_rdata_d;
    logic          inst_gnt_s, data_gnt_s;
    logic          inst_rvalid_s, data_rvalid_s;

    // Grant selection: data wins unless fetch has waited out the streak limit.
    always_comb begin
        inst_gnt_s = 1'b0;
        data_gnt_s = 1'b0;
        if (rst_i) begin
            inst_gnt_s = 1'b0;
            data_gnt_s = 1'b0;
        end else if (inst_req_i && (!data_req_i || (streak_q == STREAK_MAX))) begin
            inst_gnt_s = 1'b1;
        end else if (data_req_i) begin
            data_gnt_s = 1'b1;
        end else begin
            inst_gnt_s = 1'b0;
            data_gnt_s = 1'b0;
        end
    end

    // SRAM port mux from the granted requester; idle port is driven to zero.
    always_comb begin
        sram_en_o    = 1'b0;
        sram_wen_o   = 4'b0000;
        sram_addr_o  = {ADDR_W{1'b0}};
        sram_wdata_o = 32'h0000_0000;
        case ({inst_gnt_s, data_gnt_s})
            2'b10: begin
                sram_en_o   = 1'b1;
                sram_addr_o = inst_addr_i;
            end
            2'b01: begin
                sram_en_o    = 1'b1;
                sram_wen_o   = data_wen_i;
                sram_addr_o  = data_addr_i;
                sram_wdata_o = data_wdata_i;
            end
            default: begin
                sram_en_o    = 1'b0;
                sram_wen_o   = 4'b0000;
                sram_addr_o  = {ADDR_W{1'b0}};
                sram_wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Streak of data grants taken while a fetch is waiting.
    always_comb begin
        streak_d = streak_q;
        if (!inst_req_i || inst_gnt_s) begin
            streak_d = {SW{1'b0}};
        end else if (data_gnt_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            streak_d = streak_q;
        end
    end

    // Owner tracking and response steering; rst gates an in-flight response away.
    always_comb begin
        owner_valid_d = inst_gnt_s || (data_gnt_s && (data_wen_i == 4'b0000));
        owner_d       = data_gnt_s ? OWN_DATA : OWN_INST;
        inst_rvalid_s = owner_valid_q && (owner_q == OWN_INST) && !rst_i;
        data_rvalid_s = owner_valid_q && (owner_q == OWN_DATA) && !rst_i;
        inst_rdata_d  = inst_rvalid_s ? sram_rdata_i : inst_rdata_q;
        data_rdata_d  = data_rvalid_s ? sram_rdata_i : data_rdata_q;
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q      <= {SW{1'b0}};
            owner_valid_q <= 1'b0;
            owner_q       <= OWN_INST;
            inst_rdata_q  <= 32'h0000_0000;
            data_rdata_q  <= 32'h0000_0000;
        end else begin
            streak_q      <= streak_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign inst_gnt_o     = inst_gnt_s;
    assign data_gnt_o     = data_gnt_s;
    assign inst_rvalid_o  = inst_rvalid_s;
    assign data_rvalid_o  = data_rvalid_s;
    assign inst_rdata_o   = inst_rdata_d;
    assign data_rdata_o   = data_rdata_d;
    assign stallreq_if_o  = inst_req_i && !inst_gnt_s;
    assign stallreq_mem_o = data_req_i && !data_gnt_s;

endmodule

// File: tb/tb_sram_share_arbiter.sv
// Directed bench for sram_share_arbiter: per-cycle comparison against a behavioural
// model plus hand-computed literal expectations for the key scenarios.
module tb_sram_share_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b1;
    logic [31:0] inst_addr = 32'hBFC0_0000;
    logic        data_req = 1'b1;
    logic [3:0]  data_wen = 4'b0000;
    logic [31:0] data_addr = 32'h8000_0000;
    logic [31:0] data_wdata = 32'h0000_0000;
    logic [31:0] sram_rdata = 32'h0000_0000;

    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata, sram_wdata, sram_addr;
    logic        sram_en, stallreq_if, stallreq_mem;
    logic [3:0]  sram_wen;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_share_arbiter #(.MAX_DATA_STREAK(MAXS), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt),
        .inst_rvalid_o(inst_rvalid), .inst_rdata_o(inst_rdata),
        .data_req_i(data_req), .data_wen_i(data_wen), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata),
        .sram_en_o(sram_en), .sram_wen_o(sram_wen), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .stallreq_if_o(stallreq_if), .stallreq_mem_o(stallreq_mem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: streak count, who gets the next-cycle response, last delivered data.
    int          m_streak = 0;
    int          m_resp   = 0;   // 0 none, 1 fetch, 2 load
    logic [31:0] m_last_i = 32'h0;
    logic [31:0] m_last_d = 32'h0;

    // Compare every cycle at the falling edge, then advance the model.
    always @(negedge clk) begin
        logic        eig, edg, eirv, edrv;
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ewen;
        if (rst) begin
            eig = 1'b0; edg = 1'b0; eirv = 1'b0; edrv = 1'b0;
        end else begin
            eig  = inst_req && (!data_req || m_streak == MAXS);
            edg  = data_req && !eig;
            eirv = (m_resp == 1);
            edrv = (m_resp == 2);
        end
        eaddr  = eig ? inst_addr : (edg ? data_addr : 32'h0);
        ewen   = edg ? data_wen : 4'b0000;
        ewdata = edg ? data_wdata : 32'h0;
        chk("inst_gnt", {31'h0, inst_gnt}, {31'h0, eig});
        chk("data_gnt", {31'h0, data_gnt}, {31'h0, edg});
        chk("sram_en", {31'h0, sram_en}, {31'h0, eig | edg});
        chk("sram_addr", sram_addr, eaddr);
        chk("sram_wen", {28'h0, sram_wen}, {28'h0, ewen});
        chk("sram_wdata", sram_wdata, ewdata);
        chk("stallreq_if", {31'h0, stallreq_if}, {31'h0, inst_req & ~eig});
        chk("stallreq_mem", {31'h0, stallreq_mem}, {31'h0, data_req & ~edg});
        chk("inst_rvalid", {31'h0, inst_rvalid}, {31'h0, eirv});
        chk("data_rvalid", {31'h0, data_rvalid}, {31'h0, edrv});
        chk("inst_rdata", inst_rdata, eirv ? sram_rdata : m_last_i);
        chk("data_rdata", data_rdata, edrv ? sram_rdata : m_last_d);
        if (rst) begin
            m_streak = 0; m_resp = 0; m_last_i = 32'h0; m_last_d = 32'h0;
        end else begin
            if (eirv) m_last_i = sram_rdata;
            if (edrv) m_last_d = sram_rdata;
            m_resp = eig ? 1 : ((edg && data_wen == 4'b0000) ? 2 : 0);
            if (!inst_req || eig) m_streak = 0;
            else if (edg) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        end
    end

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [31:0] sr);
        @(posedge clk);
        #1;
        rst = r; inst_req = ir; inst_addr = ia; data_req = dr;
        data_wen = dw; data_addr = da; data_wdata = dd; sram_rdata = sr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requests high
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'hBFC0_0000, 1'b1, 4'b0000, 32'h8000_0000, 32'h0, 32'h0);
            chk("rst_gnt", {30'h0, inst_gnt, data_gnt}, 32'h0);
            chk("rst_en", {31'h0, sram_en}, 32'h0);
            chk("rst_rv", {30'h0, inst_rvalid, data_rvalid}, 32'h0);
            chk("rst_rdata", inst_rdata | data_rdata, 32'h0);
        end
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b1, 4'b0000, 32'h8000_0000, 32'h0, 32'h0);
        chk("first_gnt", {30'h0, inst_gnt, data_gnt}, 32'h1);
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0, 32'hAAAA_0001);
        chk("first_drv", data_rdata, 32'hAAAA_0001);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'hBBBB_0002);
        chk("first_irv", inst_rdata, 32'hBBBB_0002);

        // Lone fetch
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0);
        chk("lone_gnt", {31'h0, inst_gnt}, 32'h1);
        chk("lone_addr", sram_addr, 32'hBFC0_0000);
        chk("lone_stall", {31'h0, stallreq_if}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h2408_0001);
        chk("lone_rv", {31'h0, inst_rvalid}, 32'h1);
        chk("lone_rdata", inst_rdata, 32'h2408_0001);

        // Collision: load wins, fetch follows
        drive(1'b0, 1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_0010, 32'h0, 32'h0);
        chk("col_dgnt", {30'h0, inst_gnt, data_gnt}, 32'h1);
        chk("col_stall_if", {31'h0, stallreq_if}, 32'h1);
        drive(1'b0, 1'b1, 32'hBFC0_0004, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h1111_2222);
        chk("col_ignt", {31'h0, inst_gnt}, 32'h1);
        chk("col_drv", {31'h0, data_rvalid}, 32'h1);
        chk("col_drdata", data_rdata, 32'h1111_2222);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h3333_4444);
        chk("col_irv", {31'h0, inst_rvalid}, 32'h1);
        chk("col_irdata", inst_rdata, 32'h3333_4444);

        // Store
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_BEEF, 32'h0);
        chk("st_wen", {28'h0, sram_wen}, 32'h3);
        chk("st_wdata", sram_wdata, 32'h0000_BEEF);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'hDEAD_DEAD);
        chk("st_norv", {31'h0, data_rvalid}, 32'h0);
        chk("st_hold", data_rdata, 32'h1111_2222);

        // Starvation: four data grants, then fetch, then data again
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 4'b0000, 32'h8000_0100 + 32'(i * 4),
                  32'h0, 32'h5000_0000 + 32'(i));
            chk("starve_gnt", {30'h0, inst_gnt, data_gnt}, (i == 4) ? 32'h2 : 32'h1);
            if (i == 4) chk("starve_stall_mem", {31'h0, stallreq_mem}, 32'h1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h6000_0000);

        // Reset during an in-flight load
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_0040, 32'h0, 32'h0);
        chk("rml_gnt", {31'h0, data_gnt}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h5555_6666);
        chk("rml_rv1", {31'h0, data_rvalid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h7777_8888);
        chk("rml_rv2", {31'h0, data_rvalid}, 32'h0);
        chk("rml_rdata", data_rdata, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
